// File: rtl/serial_word_comparator.sv
// Purpose: magnitude compare of two WIDTH-bit words, one 4-bit slice per cycle, MSB slice first, via an external 4-bit comparator.
// Latency: result valid k edges after accept (k = slices examined, 1..NIBS); early exit on first unequal slice.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; no overlap between words.
module serial_word_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  input  logic             cmp_a_big,
  input  logic             cmp_b_big,
  input  logic             cmp_a_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_big,
  output logic             b_big,
  output logic             a_b,
  output logic             cmp_err
);

  localparam int NIBS = WIDTH / 4;
  localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  // Reject widths that cannot be split into whole slices.
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("serial_word_comparator: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  // Control FSM: accept operands, walk slices MSB first, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      a_big     <= 1'b0;
      b_big     <= 1'b0;
      a_b       <= 1'b0;
      cmp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            idx      <= IW'(NIBS - 1);
            in_ready <= 1'b0;
            state    <= SCAN;
          end else begin
            // First IDLE cycle after reset raises ready here.
            in_ready <= 1'b1;
          end
        end
        SCAN: begin
          // Flag priority a_big > b_big > equal; no flag at all is a comparator fault.
          if (cmp_a_big) begin
            a_big     <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cmp_b_big) begin
            b_big     <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cmp_a_b) begin
            if (idx == '0) begin
              a_b       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx <= idx - IW'(1);
            end
          end else begin
            cmp_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            a_big     <= 1'b0;
            b_big     <= 1'b0;
            a_b       <= 1'b0;
            cmp_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          a_big     <= 1'b0;
          b_big     <= 1'b0;
          a_b       <= 1'b0;
          cmp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Slice select toward the comparator; zero whenever no scan is in progress.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    if (state == SCAN) begin
      for (int i = 0; i < NIBS; i++) begin
        if (idx == IW'(i)) begin
          nib_a = a_reg[4*i +: 4];
          nib_b = b_reg[4*i +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Purpose: self-checking bench for serial_word_comparator (WIDTH=16) with a behavioural 4-bit comparator.
// Latency: checks result timing k edges after accept and the slice order presented each scan cycle.
// Backpressure: exercises result stall, in_ready gating, mid-scan reset and a forced comparator fault.
module tb_serial_word_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  nib_a, nib_b;
  logic        cmp_a_big, cmp_b_big, cmp_a_b;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        a_big, b_big, a_b, cmp_err;

  // Comparator override used to inject a "no flag" fault.
  logic        frc = 1'b0;
  logic [2:0]  frc_val = 3'b000;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit rep  = 0;

  // Expected results: flags {a_big,b_big,a_b,cmp_err}, slices examined, accept edge number.
  typedef struct {
    logic [3:0] f;
    int         k;
    int         acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    int          k;
  } vec_t;
  vec_t tbl[9];

  serial_word_comparator #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .nib_a     (nib_a),
    .nib_b     (nib_b),
    .cmp_a_big (cmp_a_big),
    .cmp_b_big (cmp_b_big),
    .cmp_a_b   (cmp_a_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_big     (a_big),
    .b_big     (b_big),
    .a_b       (a_b),
    .cmp_err   (cmp_err)
  );

  assign cmp_a_big = frc ? frc_val[2] : (nib_a > nib_b);
  assign cmp_b_big = frc ? frc_val[1] : (nib_b > nib_a);
  assign cmp_a_b   = frc ? frc_val[0] : (nib_a == nib_b);

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sl(input logic [15:0] w, input int j);
    return 4'(w >> (12 - 4*j));
  endfunction

  // Reference: first differing slice from the MSB decides; otherwise equal after 4 slices.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [3:0] f, output int k);
    bit found = 0;
    f = 4'b0010;
    k = 4;
    for (int j = 0; j < 4; j++) begin
      if (!found && sl(a, j) != sl(b, j)) begin
        found = 1;
        k = j + 1;
        f = (sl(a, j) > sl(b, j)) ? 4'b1000 : 4'b0100;
      end
    end
  endfunction

  // Result monitor: latency on first sight, flags/ready/slice outputs every cycle held.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_result: got out_valid=1 want 0 (cycle %0d)", cyc);
      end else begin
        if (!rep) begin
          rep = 1;
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].k));
        end
        chk("result_flags", {28'd0, a_big, b_big, a_b, cmp_err}, {28'd0, sb[0].f});
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        chk("nib_outside_scan", {24'd0, nib_a, nib_b}, 32'd0);
      end
    end
  end

  // Retire the expected entry on the result handshake edge.
  always @(posedge clk) begin
    if (!rst_n) rep = 0;
    else if (out_valid && out_ready && sb.size() > 0) begin
      void'(sb.pop_front());
      rep = 0;
    end
  end

  // Present operands and wait until the next edge will accept them.
  task automatic offer(input logic [15:0] a, input logic [15:0] b, output bit got);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    got = 0;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input int k, input int stall);
    bit got;
    out_ready = (stall == 0);
    offer(a, b, got);
    if (!got) return;
    sb.push_back('{f: f, k: k, acc: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      chk("nib_a", {28'd0, nib_a}, {28'd0, sl(a, j)});
      chk("nib_b", {28'd0, nib_b}, {28'd0, sl(b, j)});
    end
    got = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("result_timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
      return;
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    logic [15:0] ra, rb;
    logic [3:0]  rf;
    int          rk;

    tbl[0] = '{16'h8000, 16'h7FFF, 4'b1000, 1};
    tbl[1] = '{16'h1234, 16'h1235, 4'b0100, 4};
    tbl[2] = '{16'hBEEF, 16'hBEEF, 4'b0010, 4};
    tbl[3] = '{16'h0001, 16'h0000, 4'b1000, 4};
    tbl[4] = '{16'h00F0, 16'h0100, 4'b0100, 2};
    tbl[5] = '{16'hFFFF, 16'h0000, 4'b1000, 1};
    tbl[6] = '{16'h0000, 16'h0000, 4'b0010, 4};
    tbl[7] = '{16'h5A00, 16'h5A10, 4'b0100, 3};
    tbl[8] = '{16'h7FFF, 16'h8000, 4'b0100, 1};

    // Reset state before any clock edge.
    #3;
    chk("reset_outputs", {18'd0, in_ready, out_valid, a_big, b_big, a_b, cmp_err, nib_a, nib_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 9; i++)
      run_vec(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].k, 0);

    // Result stall: held three cycles before the consumer takes it.
    run_vec(16'h1234, 16'h1235, 4'b0100, 4, 3);

    // Random pairs, many sharing leading slices.
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = ra;
      if (i % 4 != 3) rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      model(ra, rb, rf, rk);
      run_vec(ra, rb, rf, rk, i % 2);
    end

    // Comparator returns no flag on the first scan cycle.
    frc = 1'b1;
    frc_val = 3'b000;
    run_vec(16'h8000, 16'h7FFF, 4'b0001, 1, 0);
    frc = 1'b0;

    // Reset during the second scan cycle aborts the word.
    offer(16'h1234, 16'h1235, got);
    if (got) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_scan_nib", {24'd0, nib_a, nib_b}, 32'h22);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {18'd0, in_ready, out_valid, a_big, b_big, a_b, cmp_err, nib_a, nib_b}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_abort", {31'd0, in_ready}, 32'd1);
      run_vec(16'h0001, 16'h0000, 4'b1000, 4, 0);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
